// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: request/grant bus plus multiplier start/done handshake.
// Parameters: NREQ requesters, WIDTH-bit operands.
// Client side: req, a_bus, b_bus in; gnt, ack, result, err out.
// Multiplier side: mul_start, mul_a, mul_b out; mul_result, mul_done in.
// The slave modport is the arbiter's view; the master modport drives it.
interface booth_mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [2*WIDTH-1:0]    result;
  logic [2*WIDTH-1:0]    mul_result;
  logic                  err;
  logic                  mul_start;
  logic                  mul_done;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  modport master (
    output req, a_bus, b_bus, mul_result, mul_done,
    input  gnt, ack, result, err, mul_start, mul_a, mul_b
  );
  modport slave (
    input  req, a_bus, b_bus, mul_result, mul_done,
    output gnt, ack, result, err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin arbiter sharing one Booth multiplier among NREQ clients.
// Ports: clock (rising edge), _reset (synchronous, active-low),
//   bus (booth_mult_arbiter_if.slave): req/a_bus/b_bus in, gnt/ack/result/err out,
//   mul_start/mul_a/mul_b out, mul_result/mul_done in.
// Optional macro BOOTH_ARB_WATCHDOG_EN: abort WAIT after TIMEOUT cycles with err and result=0.
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input logic                 clock,
  input logic                 _reset,
  booth_mult_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, gidx_q, gidx_d, win;
  logic [NREQ-1:0]    gnt_q, gnt_d, ack_q, ack_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               start_q, start_d, err_q, err_d;
`ifdef BOOTH_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               to_q, to_d;
`endif
  // Scan offsets high-to-low so the nearest requester at or above ptr is assigned last.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    rr_pick = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = int'(p) + i;
      if (j >= NREQ) j -= NREQ;
      if (r[j]) rr_pick = PW'(j);
    end
  endfunction
  assign win = rr_pick(bus.req, ptr_q);
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = 1'b0;
    start_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef BOOTH_ARB_WATCHDOG_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: if (|bus.req) begin
        gidx_d  = win;
        gnt_d   = NREQ'(1) << win;
        a_d     = bus.a_bus[win*WIDTH +: WIDTH];
        b_d     = bus.b_bus[win*WIDTH +: WIDTH];
        state_d = LAUNCH;
      end
      // start is registered here so it is high for exactly the first WAIT cycle
      LAUNCH: begin
        start_d = 1'b1;
        state_d = WAIT;
`ifdef BOOTH_ARB_WATCHDOG_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      WAIT: if (bus.mul_done) begin
        result_d = bus.mul_result;
        state_d  = RESP;
      end
`ifdef BOOTH_ARB_WATCHDOG_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        result_d = '0;
        to_d     = 1'b1;
        state_d  = RESP;
      end else cnt_d = cnt_q + 1'b1;
`endif
      // ack/err are registered on leaving RESP, so they appear in the following IDLE cycle
      RESP: begin
        ack_d   = gnt_q;
`ifdef BOOTH_ARB_WATCHDOG_EN
        err_d   = to_q;
`endif
        gnt_d   = '0;
        ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!_reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef BOOTH_ARB_WATCHDOG_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef BOOTH_ARB_WATCHDOG_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.mul_start = start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
endmodule
